// File: rtl/axilite_arbiter_2to1_if.sv
// AXI4-Lite bundle shared by the two upstream masters and the downstream slave.
// AXI_ACLK/AXI_ARESETN travel with the bundle but the arbiter runs on its own clock/reset.
interface axilite_int #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8
);
  logic                          AXI_ACLK;
  logic                          AXI_ARESETN;
  logic [C_AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                    AWPROT;
  logic                          AWVALID;
  logic                          AWREADY;
  logic [C_AXI_DATA_WIDTH-1:0]   WDATA;
  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                          WVALID;
  logic                          WREADY;
  logic [1:0]                    BRESP;
  logic                          BVALID;
  logic                          BREADY;
  logic [C_AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                    ARPROT;
  logic                          ARVALID;
  logic                          ARREADY;
  logic [C_AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                    RRESP;
  logic                          RVALID;
  logic                          RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axilite_arbiter_2to1.sv
// Round-robin 2:1 AXI4-Lite arbiter; read and write channels each hold one outstanding
// transaction. Handshake rule: a transfer happens on a clock edge where VALID && READY.
module axilite_arbiter_2to1 #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8
) (
  input  logic       AXI_ACLK,
  input  logic       AXI_ARESET,
  axilite_int.slave  s0,
  axilite_int.slave  s1,
  axilite_int.master m,
  output logic [1:0] rd_grant,
  output logic [1:0] wr_grant,
  output logic [1:0] rd_state_dbg,
  output logic [1:0] wr_state_dbg
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} wr_state_t;

  rd_state_t rd_state, rd_state_nxt;
  wr_state_t wr_state, wr_state_nxt;
  logic [1:0] rd_grant_nxt, wr_grant_nxt;
  logic rd_pri, rd_pri_nxt, wr_pri, wr_pri_nxt;
  logic aw_done, aw_done_nxt, w_done, w_done_nxt;

  logic [C_AXI_ADDR_WIDTH-1:0]   ar_addr_sel, aw_addr_sel;
  logic [C_AXI_DATA_WIDTH-1:0]   w_data_sel;
  logic [C_AXI_DATA_WIDTH/8-1:0] w_strb_sel;
  logic ar_valid, r_ready, aw_valid, w_valid, b_ready;

  // pri=0 favours s0 under contention; a lone requester always wins
  function automatic logic [1:0] pick(input logic req0, input logic req1, input logic pri);
    if (req0 && (!req1 || !pri)) return 2'b01;
    else if (req1)               return 2'b10;
    else                         return 2'b00;
  endfunction

  assign rd_state_dbg = rd_state;
  assign wr_state_dbg = wr_state;

  assign ar_addr_sel = rd_grant[1] ? s1.ARADDR : s0.ARADDR;
  assign aw_addr_sel = wr_grant[1] ? s1.AWADDR : s0.AWADDR;
  assign w_data_sel  = wr_grant[1] ? s1.WDATA  : s0.WDATA;
  assign w_strb_sel  = wr_grant[1] ? s1.WSTRB  : s0.WSTRB;

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      rd_state <= R_IDLE;
      rd_grant <= 2'b00;
      rd_pri   <= 1'b0;
      wr_state <= W_IDLE;
      wr_grant <= 2'b00;
      wr_pri   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_grant <= rd_grant_nxt;
      rd_pri   <= rd_pri_nxt;
      wr_state <= wr_state_nxt;
      wr_grant <= wr_grant_nxt;
      wr_pri   <= wr_pri_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_grant_nxt = rd_grant;
    rd_pri_nxt   = rd_pri;
    ar_valid     = 1'b0;
    r_ready      = 1'b0;
    m.ARADDR     = ar_addr_sel;
    m.ARPROT     = rd_grant[1] ? s1.ARPROT : s0.ARPROT;
    m.ARVALID    = 1'b0;
    m.RREADY     = 1'b0;
    s0.ARREADY   = 1'b0;
    s1.ARREADY   = 1'b0;
    s0.RVALID    = 1'b0;
    s1.RVALID    = 1'b0;
    s0.RDATA     = m.RDATA;
    s1.RDATA     = m.RDATA;
    s0.RRESP     = m.RRESP;
    s1.RRESP     = m.RRESP;
    case (rd_state)
      R_IDLE: begin
        if (s0.ARVALID || s1.ARVALID) begin
          rd_grant_nxt = pick(s0.ARVALID, s1.ARVALID, rd_pri);
          rd_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        ar_valid   = rd_grant[1] ? s1.ARVALID : s0.ARVALID;
        m.ARVALID  = ar_valid;
        s0.ARREADY = rd_grant[0] && m.ARREADY;
        s1.ARREADY = rd_grant[1] && m.ARREADY;
        if (ar_valid && m.ARREADY) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        r_ready   = rd_grant[1] ? s1.RREADY : s0.RREADY;
        m.RREADY  = r_ready;
        s0.RVALID = rd_grant[0] && m.RVALID;
        s1.RVALID = rd_grant[1] && m.RVALID;
        if (m.RVALID && r_ready) begin
          rd_state_nxt = R_IDLE;
          rd_grant_nxt = 2'b00;
          rd_pri_nxt   = rd_grant[0];
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_grant_nxt = wr_grant;
    wr_pri_nxt   = wr_pri;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    aw_valid     = 1'b0;
    w_valid      = 1'b0;
    b_ready      = 1'b0;
    m.AWADDR     = aw_addr_sel;
    m.AWPROT     = wr_grant[1] ? s1.AWPROT : s0.AWPROT;
    m.AWVALID    = 1'b0;
    m.WDATA      = w_data_sel;
    m.WSTRB      = w_strb_sel;
    m.WVALID     = 1'b0;
    m.BREADY     = 1'b0;
    s0.AWREADY   = 1'b0;
    s1.AWREADY   = 1'b0;
    s0.WREADY    = 1'b0;
    s1.WREADY    = 1'b0;
    s0.BVALID    = 1'b0;
    s1.BVALID    = 1'b0;
    s0.BRESP     = m.BRESP;
    s1.BRESP     = m.BRESP;
    case (wr_state)
      W_IDLE: begin
        if (s0.AWVALID || s0.WVALID || s1.AWVALID || s1.WVALID) begin
          wr_grant_nxt = pick(s0.AWVALID || s0.WVALID, s1.AWVALID || s1.WVALID, wr_pri);
          wr_state_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        // each channel is masked off once its own handshake has been taken
        aw_valid   = !aw_done && (wr_grant[1] ? s1.AWVALID : s0.AWVALID);
        w_valid    = !w_done  && (wr_grant[1] ? s1.WVALID  : s0.WVALID);
        m.AWVALID  = aw_valid;
        m.WVALID   = w_valid;
        s0.AWREADY = wr_grant[0] && !aw_done && m.AWREADY;
        s1.AWREADY = wr_grant[1] && !aw_done && m.AWREADY;
        s0.WREADY  = wr_grant[0] && !w_done && m.WREADY;
        s1.WREADY  = wr_grant[1] && !w_done && m.WREADY;
        aw_done_nxt = aw_done || (aw_valid && m.AWREADY);
        w_done_nxt  = w_done  || (w_valid && m.WREADY);
        if (aw_done_nxt && w_done_nxt) wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        b_ready   = wr_grant[1] ? s1.BREADY : s0.BREADY;
        m.BREADY  = b_ready;
        s0.BVALID = wr_grant[0] && m.BVALID;
        s1.BVALID = wr_grant[1] && m.BVALID;
        if (m.BVALID && b_ready) begin
          wr_state_nxt = W_IDLE;
          wr_grant_nxt = 2'b00;
          wr_pri_nxt   = wr_grant[0];
          aw_done_nxt  = 1'b0;
          w_done_nxt   = 1'b0;
        end
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axilite_arbiter_2to1.sv
// Directed bench for axilite_arbiter_2to1: the bench plays both masters and the slave,
// stepping one cycle at a time and comparing against hand-computed values.
module tb_axilite_arbiter_2to1;
  logic clk;
  logic rst;
  logic [1:0] rd_grant, wr_grant, rd_state_dbg, wr_state_dbg;
  int checks;
  int failures;
  int ar_hs_cnt, aw_hs_cnt, w_hs_cnt;
  logic [7:0] exp_q[$];

  axilite_int #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8)) s0_if ();
  axilite_int #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8)) s1_if ();
  axilite_int #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8)) m_if ();

  assign s0_if.AXI_ACLK = clk;
  assign s1_if.AXI_ACLK = clk;
  assign m_if.AXI_ACLK  = clk;
  assign s0_if.AXI_ARESETN = ~rst;
  assign s1_if.AXI_ARESETN = ~rst;
  assign m_if.AXI_ARESETN  = ~rst;

  axilite_arbiter_2to1 #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8)) dut (
    .AXI_ACLK    (clk),
    .AXI_ARESET  (rst),
    .s0          (s0_if),
    .s1          (s1_if),
    .m           (m_if),
    .rd_grant    (rd_grant),
    .wr_grant    (wr_grant),
    .rd_state_dbg(rd_state_dbg),
    .wr_state_dbg(wr_state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // settle, count m-side handshakes for this cycle, then advance to just past the edge
  task automatic step();
    #1;
    if (m_if.ARVALID && m_if.ARREADY) ar_hs_cnt++;
    if (m_if.AWVALID && m_if.AWREADY) aw_hs_cnt++;
    if (m_if.WVALID && m_if.WREADY)   w_hs_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    s0_if.ARADDR = '0; s0_if.ARPROT = '0; s0_if.ARVALID = 1'b0; s0_if.RREADY = 1'b0;
    s0_if.AWADDR = '0; s0_if.AWPROT = '0; s0_if.AWVALID = 1'b0;
    s0_if.WDATA = '0; s0_if.WSTRB = '0; s0_if.WVALID = 1'b0; s0_if.BREADY = 1'b0;
    s1_if.ARADDR = '0; s1_if.ARPROT = '0; s1_if.ARVALID = 1'b0; s1_if.RREADY = 1'b0;
    s1_if.AWADDR = '0; s1_if.AWPROT = '0; s1_if.AWVALID = 1'b0;
    s1_if.WDATA = '0; s1_if.WSTRB = '0; s1_if.WVALID = 1'b0; s1_if.BREADY = 1'b0;
    m_if.ARREADY = 1'b0; m_if.RDATA = '0; m_if.RRESP = '0; m_if.RVALID = 1'b0;
    m_if.AWREADY = 1'b0; m_if.WREADY = 1'b0; m_if.BRESP = '0; m_if.BVALID = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // driver tasks for the upstream write channels
  task automatic set_wr(input bit p, input bit awv, input bit wv,
                        input logic [7:0] addr, input logic [31:0] data);
    if (p) begin
      s1_if.AWVALID = awv; s1_if.AWADDR = addr;
      s1_if.WVALID = wv; s1_if.WDATA = data; s1_if.WSTRB = 4'hF;
    end else begin
      s0_if.AWVALID = awv; s0_if.AWADDR = addr;
      s0_if.WVALID = wv; s0_if.WDATA = data; s0_if.WSTRB = 4'hF;
    end
  endtask

  task automatic set_bready(input bit p, input bit v);
    if (p) s1_if.BREADY = v;
    else   s0_if.BREADY = v;
  endtask

  // complete write from a lone master against a zero-wait slave
  task automatic do_write(input bit p, input logic [7:0] addr, input logic [31:0] data,
                          input logic [1:0] bresp);
    set_wr(p, 1'b1, 1'b1, addr, data);
    m_if.AWREADY = 1'b1; m_if.WREADY = 1'b1;
    step();
    check("wr_grant_lone", wr_grant, p ? 2'b10 : 2'b01);
    check("wr_awaddr", m_if.AWADDR, addr);
    check("wr_wdata", m_if.WDATA, data);
    step();
    set_wr(p, 1'b0, 1'b0, addr, data);
    m_if.BVALID = 1'b1; m_if.BRESP = bresp;
    set_bready(p, 1'b1);
    #1;
    check("wr_bvalid", p ? s1_if.BVALID : s0_if.BVALID, 1'b1);
    check("wr_bresp", p ? s1_if.BRESP : s0_if.BRESP, bresp);
    step();
    m_if.BVALID = 1'b0;
    set_bready(p, 1'b0);
    check("wr_grant_done", wr_grant, 2'b00);
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [7:0] a;
    int cnt0, cnt1;
    bit e;
    checks = 0; failures = 0;
    ar_hs_cnt = 0; aw_hs_cnt = 0; w_hs_cnt = 0;
    rst = 1'b0;
    init_inputs();
    // reset state, with the slave offering every READY/VALID so nothing leaks through
    m_if.ARREADY = 1'b1; m_if.AWREADY = 1'b1; m_if.WREADY = 1'b1;
    m_if.RVALID = 1'b1; m_if.BVALID = 1'b1;
    do_reset();
    #1;
    check("rst_rd_grant", rd_grant, 2'b00);
    check("rst_wr_grant", wr_grant, 2'b00);
    check("rst_m_arvalid", m_if.ARVALID, 1'b0);
    check("rst_m_awvalid", m_if.AWVALID, 1'b0);
    check("rst_m_wvalid", m_if.WVALID, 1'b0);
    check("rst_m_rready", m_if.RREADY, 1'b0);
    check("rst_m_bready", m_if.BREADY, 1'b0);
    check("rst_s0_arready", s0_if.ARREADY, 1'b0);
    check("rst_s0_rvalid", s0_if.RVALID, 1'b0);
    check("rst_s1_bvalid", s1_if.BVALID, 1'b0);
    check("rst_s1_wready", s1_if.WREADY, 1'b0);
    init_inputs();

    // single read from s0
    s0_if.ARVALID = 1'b1; s0_if.ARADDR = 8'h10;
    #1;
    check("rd1_idle_arvalid", m_if.ARVALID, 1'b0);
    step();
    check("rd1_grant", rd_grant, 2'b01);
    check("rd1_arvalid", m_if.ARVALID, 1'b1);
    check("rd1_araddr", m_if.ARADDR, 8'h10);
    m_if.ARREADY = 1'b1;
    #1;
    check("rd1_s0_arready", s0_if.ARREADY, 1'b1);
    check("rd1_s1_arready", s1_if.ARREADY, 1'b0);
    step();
    s0_if.ARVALID = 1'b0; m_if.ARREADY = 1'b0;
    m_if.RVALID = 1'b1; m_if.RDATA = 32'hDEADBEEF; m_if.RRESP = 2'b00;
    s0_if.RREADY = 1'b1;
    #1;
    check("rd1_s0_rvalid", s0_if.RVALID, 1'b1);
    check("rd1_s0_rdata", s0_if.RDATA, 32'hDEADBEEF);
    check("rd1_s0_rresp", s0_if.RRESP, 2'b00);
    check("rd1_s1_rvalid", s1_if.RVALID, 1'b0);
    check("rd1_m_rready", m_if.RREADY, 1'b1);
    step();
    m_if.RVALID = 1'b0; s0_if.RREADY = 1'b0;
    check("rd1_grant_done", rd_grant, 2'b00);

    // contention: 4 reads from each master, expect strict alternation starting with s0
    do_reset();
    ar_hs_cnt = 0;
    for (int t = 0; t < 8; t++) exp_q.push_back((t % 2 == 0) ? 8'h40 + 8'(4 * (t / 2)) : 8'h80 + 8'(4 * (t / 2)));
    cnt0 = 0; cnt1 = 0;
    m_if.ARREADY = 1'b1;
    s0_if.RREADY = 1'b1; s1_if.RREADY = 1'b1;
    for (int t = 0; t < 8; t++) begin
      s0_if.ARVALID = (cnt0 < 4); s0_if.ARADDR = 8'h40 + 8'(4 * cnt0);
      s1_if.ARVALID = (cnt1 < 4); s1_if.ARADDR = 8'h80 + 8'(4 * cnt1);
      step();
      e = (t % 2 == 1);
      a = exp_q.pop_front();
      check("cont_grant", rd_grant, e ? 2'b10 : 2'b01);
      check("cont_araddr", m_if.ARADDR, a);
      step();
      if (e) begin
        cnt1++;
        s1_if.ARVALID = (cnt1 < 4); s1_if.ARADDR = 8'h80 + 8'(4 * cnt1);
      end else begin
        cnt0++;
        s0_if.ARVALID = (cnt0 < 4); s0_if.ARADDR = 8'h40 + 8'(4 * cnt0);
      end
      m_if.RVALID = 1'b1; m_if.RDATA = {24'hD00000, a};
      #1;
      check("cont_rdata", e ? s1_if.RDATA : s0_if.RDATA, {24'hD00000, a});
      check("cont_rvalid_own", e ? s1_if.RVALID : s0_if.RVALID, 1'b1);
      check("cont_rvalid_other", e ? s0_if.RVALID : s1_if.RVALID, 1'b0);
      step();
      m_if.RVALID = 1'b0;
    end
    check("cont_ar_count", ar_hs_cnt, 8);
    check("cont_q_empty", exp_q.size(), 0);
    init_inputs();

    // s1 write with W two cycles ahead of AW; W stays high after its handshake
    aw_hs_cnt = 0; w_hs_cnt = 0;
    m_if.AWREADY = 1'b1; m_if.WREADY = 1'b1;
    s1_if.WVALID = 1'b1; s1_if.WDATA = 32'hA5A5A5A5; s1_if.WSTRB = 4'hF;
    step();
    check("wfirst_grant", wr_grant, 2'b10);
    check("wfirst_wvalid", m_if.WVALID, 1'b1);
    check("wfirst_wdata", m_if.WDATA, 32'hA5A5A5A5);
    check("wfirst_wstrb", m_if.WSTRB, 4'hF);
    check("wfirst_awvalid", m_if.AWVALID, 1'b0);
    check("wfirst_s1_wready", s1_if.WREADY, 1'b1);
    step();
    s1_if.AWVALID = 1'b1; s1_if.AWADDR = 8'h20;
    #1;
    check("wfirst_awvalid2", m_if.AWVALID, 1'b1);
    check("wfirst_awaddr", m_if.AWADDR, 8'h20);
    check("wfirst_wvalid_masked", m_if.WVALID, 1'b0);
    check("wfirst_s1_wready_masked", s1_if.WREADY, 1'b0);
    step();
    s1_if.AWVALID = 1'b0; s1_if.WVALID = 1'b0;
    m_if.BVALID = 1'b1; m_if.BRESP = 2'b00; s1_if.BREADY = 1'b1;
    #1;
    check("wfirst_state_resp", wr_state_dbg, 2'd2);
    check("wfirst_s1_bvalid", s1_if.BVALID, 1'b1);
    check("wfirst_s1_bresp", s1_if.BRESP, 2'b00);
    check("wfirst_s0_bvalid", s0_if.BVALID, 1'b0);
    check("wfirst_m_bready", m_if.BREADY, 1'b1);
    step();
    m_if.BVALID = 1'b0; s1_if.BREADY = 1'b0;
    check("wfirst_grant_done", wr_grant, 2'b00);
    check("wfirst_aw_count", aw_hs_cnt, 1);
    check("wfirst_w_count", w_hs_cnt, 1);

    // concurrent: s0 reads while s1 writes
    m_if.ARREADY = 1'b1;
    s0_if.ARVALID = 1'b1; s0_if.ARADDR = 8'h04;
    set_wr(1'b1, 1'b1, 1'b1, 8'h08, 32'h12345678);
    step();
    check("conc_rd_grant", rd_grant, 2'b01);
    check("conc_wr_grant", wr_grant, 2'b10);
    check("conc_araddr", m_if.ARADDR, 8'h04);
    check("conc_awaddr", m_if.AWADDR, 8'h08);
    check("conc_wdata", m_if.WDATA, 32'h12345678);
    step();
    s0_if.ARVALID = 1'b0;
    set_wr(1'b1, 1'b0, 1'b0, 8'h08, 32'h12345678);
    m_if.RVALID = 1'b1; m_if.RDATA = 32'hCAFEF00D; m_if.BVALID = 1'b1; m_if.BRESP = 2'b00;
    s0_if.RREADY = 1'b1; s1_if.BREADY = 1'b1;
    #1;
    check("conc_s0_rvalid", s0_if.RVALID, 1'b1);
    check("conc_s0_rdata", s0_if.RDATA, 32'hCAFEF00D);
    check("conc_s1_bvalid", s1_if.BVALID, 1'b1);
    step();
    init_inputs();
    check("conc_rd_done", rd_grant, 2'b00);
    check("conc_wr_done", wr_grant, 2'b00);

    // slave backpressure on s0 while s1 waits
    s0_if.ARVALID = 1'b1; s0_if.ARADDR = 8'h30;
    step();
    s1_if.ARVALID = 1'b1; s1_if.ARADDR = 8'h34;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ar_grant", rd_grant, 2'b01);
      check("bp_ar_addr", m_if.ARADDR, 8'h30);
      check("bp_s1_arready", s1_if.ARREADY, 1'b0);
      step();
    end
    m_if.ARREADY = 1'b1;
    step();
    s0_if.ARVALID = 1'b0; m_if.ARREADY = 1'b0;
    m_if.RVALID = 1'b1; m_if.RDATA = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_r_s0_rvalid", s0_if.RVALID, 1'b1);
      check("bp_r_m_rready", m_if.RREADY, 1'b0);
      check("bp_r_m_arvalid", m_if.ARVALID, 1'b0);
      check("bp_r_grant", rd_grant, 2'b01);
      step();
    end
    s0_if.RREADY = 1'b1;
    step();
    m_if.RVALID = 1'b0; s0_if.RREADY = 1'b0;
    check("bp_idle_grant", rd_grant, 2'b00);
    step();
    check("bp_s1_grant", rd_grant, 2'b10);
    check("bp_s1_araddr", m_if.ARADDR, 8'h34);
    check("bp_s1_arvalid", m_if.ARVALID, 1'b1);
    m_if.ARREADY = 1'b1;
    step();
    s1_if.ARVALID = 1'b0; m_if.ARREADY = 1'b0;
    m_if.RVALID = 1'b1; s1_if.RREADY = 1'b1;
    #1;
    check("bp_s1_rvalid", s1_if.RVALID, 1'b1);
    step();
    init_inputs();

    // reset while in W_RESP; wr_pri is 1 at that point and must come back as 0
    do_write(1'b0, 8'h50, 32'h11112222, 2'b10);
    set_wr(1'b1, 1'b1, 1'b1, 8'h54, 32'h55556666);
    m_if.AWREADY = 1'b1; m_if.WREADY = 1'b1;
    step();
    check("rstw_grant", wr_grant, 2'b10);
    step();
    set_wr(1'b1, 1'b0, 1'b0, 8'h54, 32'h55556666);
    m_if.BVALID = 1'b1;
    #1;
    check("rstw_in_resp", wr_state_dbg, 2'd2);
    check("rstw_s1_bvalid", s1_if.BVALID, 1'b1);
    rst = 1'b1;
    #1;
    check("rstw_bvalid_drop", s1_if.BVALID, 1'b0);
    check("rstw_grant_drop", wr_grant, 2'b00);
    check("rstw_state_idle", wr_state_dbg, 2'd0);
    check("rstw_awready_drop", s1_if.AWREADY, 1'b0);
    #2;
    rst = 1'b0;
    m_if.BVALID = 1'b0;
    set_wr(1'b0, 1'b1, 1'b1, 8'h60, 32'h0000AAAA);
    set_wr(1'b1, 1'b1, 1'b1, 8'h64, 32'h0000BBBB);
    step();
    check("rstw_pri_s0_wins", wr_grant, 2'b01);
    step();
    set_wr(1'b0, 1'b0, 1'b0, 8'h60, 32'h0000AAAA);
    m_if.BVALID = 1'b1; m_if.BRESP = 2'b00; s0_if.BREADY = 1'b1;
    step();
    m_if.BVALID = 1'b0; s0_if.BREADY = 1'b0;
    step();
    check("rstw_s1_grant", wr_grant, 2'b10);
    check("rstw_s1_awaddr", m_if.AWADDR, 8'h64);
    check("rstw_s1_wdata", m_if.WDATA, 32'h0000BBBB);
    step();
    set_wr(1'b1, 1'b0, 1'b0, 8'h64, 32'h0000BBBB);
    m_if.BVALID = 1'b1; m_if.BRESP = 2'b00; s1_if.BREADY = 1'b1;
    #1;
    check("rstw_s1_bvalid2", s1_if.BVALID, 1'b1);
    check("rstw_s1_bresp", s1_if.BRESP, 2'b00);
    step();
    init_inputs();
    check("rstw_done", wr_grant, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
